// File: rtl/branch_resolve_unit.sv
// Resolves queued branch predictions at EX against the real outcome: on a mispredict it
// flushes wrong-path work, redirects fetch, and feeds the outcome back to the predictor.
module branch_resolve_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_push,
  input  logic            id_pred_taken,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_target,
  input  logic            ex_resolve,
  input  logic            ex_taken,
  output logic            bq_full,
  output logic            flush,
  output logic            redirect_vld,
  output logic [XLEN-1:0] redirect_pc,
  output logic            upd_is_branch,
  output logic            upd_taken,
  output logic            underflow,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic {RUN, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            redirect_vld_q, redirect_vld_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            upd_is_branch_q, upd_is_branch_d;
  logic            upd_taken_q, upd_taken_d;
  logic            underflow_q, underflow_d;
  logic [CNT_W-1:0] br_count_q, br_count_d, miss_count_q, miss_count_d;

  logic            pred_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] tgt_mem  [DEPTH];

  logic            push_ok, pop, mispredict, full;
  logic            head_pred;
  logic [XLEN-1:0] head_pc, head_tgt;

  assign full      = (count_q == CW'(DEPTH));
  assign head_pred = pred_mem[rd_ptr_q];
  assign head_pc   = pc_mem[rd_ptr_q];
  assign head_tgt  = tgt_mem[rd_ptr_q];

  always_comb begin
    state_d         = state_q;
    fcnt_d          = fcnt_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    redirect_vld_d  = 1'b0;
    redirect_pc_d   = redirect_pc_q;
    upd_is_branch_d = 1'b0;
    upd_taken_d     = upd_taken_q;
    underflow_d     = underflow_q;
    br_count_d      = br_count_q;
    miss_count_d    = miss_count_q;
    push_ok         = 1'b0;
    pop             = 1'b0;
    mispredict      = 1'b0;

    unique case (state_q)
      RUN: begin
        pop        = ex_resolve && (count_q != '0);
        mispredict = pop && (head_pred != ex_taken);
        if (ex_resolve && (count_q == '0)) underflow_d = 1'b1;
        if (pop) begin
          upd_is_branch_d = 1'b1;
          upd_taken_d     = ex_taken;
          if (br_count_q != '1) br_count_d = br_count_q + CNT_W'(1);
        end
        if (mispredict) begin
          // Everything younger than the head was fetched down the wrong path.
          if (miss_count_q != '1) miss_count_d = miss_count_q + CNT_W'(1);
          wr_ptr_d       = '0;
          rd_ptr_d       = '0;
          count_d        = '0;
          state_d        = FLUSH;
          fcnt_d         = FW'(FLUSH_CYC - 1);
          redirect_vld_d = 1'b1;
          redirect_pc_d  = ex_taken ? head_tgt : head_pc + XLEN'(4);
        end else begin
          push_ok = id_push && (!full || pop);
          if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
          if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
          count_d = count_q + CW'(push_ok) - CW'(pop);
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) state_d = RUN;
        else              fcnt_d  = fcnt_q - FW'(1);
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      fcnt_q          <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      redirect_vld_q  <= 1'b0;
      redirect_pc_q   <= '0;
      upd_is_branch_q <= 1'b0;
      upd_taken_q     <= 1'b0;
      underflow_q     <= 1'b0;
      br_count_q      <= '0;
      miss_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      fcnt_q          <= fcnt_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      redirect_vld_q  <= redirect_vld_d;
      redirect_pc_q   <= redirect_pc_d;
      upd_is_branch_q <= upd_is_branch_d;
      upd_taken_q     <= upd_taken_d;
      underflow_q     <= underflow_d;
      br_count_q      <= br_count_d;
      miss_count_q    <= miss_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      pred_mem[wr_ptr_q] <= id_pred_taken;
      pc_mem[wr_ptr_q]   <= id_pc;
      tgt_mem[wr_ptr_q]  <= id_target;
    end
  end

  assign bq_full       = full;
  assign flush         = (state_q == FLUSH);
  assign redirect_vld  = redirect_vld_q;
  assign redirect_pc   = redirect_pc_q;
  assign upd_is_branch = upd_is_branch_q;
  assign upd_taken     = upd_taken_q;
  assign underflow     = underflow_q;
  assign br_count      = br_count_q;
  assign miss_count    = miss_count_q;

endmodule
